// File: rtl/cu_sequencer_if.sv
// Datapath-side bus of the control unit: opcode/flags/memory handshake in,
// control lines and memory strobes out.
interface cu_sequencer_if #(
  parameter int OPCODE_W = 8
);
  logic [OPCODE_W-1:0] opcode;
  logic [4:0]          flags;
  logic                mem_ready;
  logic [15:0]         ctrl;
  logic [3:0]          alu_op;
  logic                mar_inc;
  logic                mem_rd;
  logic                mem_wr;

  modport master (
    input  opcode, flags, mem_ready,
    output ctrl, alu_op, mar_inc, mem_rd, mem_wr
  );

  modport slave (
    output opcode, flags, mem_ready,
    input  ctrl, alu_op, mar_inc, mem_rd, mem_wr
  );
endinterface

// File: rtl/cu_sequencer.sv
// Hardwired fetch/decode/execute microsequencer (Moore) for the register datapath.
// Optional single-step gating before every fetch: define CU_SINGLE_STEP_EN.
module cu_sequencer #(
  parameter int OPCODE_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
  cu_sequencer_if.master   bus,
  output logic             o_halt,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic [3:0]       o_state
);

`ifdef CU_SINGLE_STEP_EN
  typedef enum logic [3:0] {
    IDLE = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3, D1 = 4'd4, D2 = 4'd5,
    E1 = 4'd6, E2 = 4'd7, E3 = 4'd8, HALTED = 4'd9, STEP_WAIT = 4'd10
  } state_t;
  localparam state_t FETCH_ENTRY = STEP_WAIT;
`else
  typedef enum logic [3:0] {
    IDLE = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3, D1 = 4'd4, D2 = 4'd5,
    E1 = 4'd6, E2 = 4'd7, E3 = 4'd8, HALTED = 4'd9
  } state_t;
  localparam state_t FETCH_ENTRY = F1;
`endif

  typedef enum logic [2:0] {
    K_LOAD, K_STORE, K_ALU, K_JMP, K_JGEZ, K_HALT, K_ILL
  } kind_t;

  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_ADD    = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_SUB    = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_JMPGEZ = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_JMP    = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OP_MPY    = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OP_AND    = OPCODE_W'(8'h0A);
  localparam logic [OPCODE_W-1:0] OP_OR     = OPCODE_W'(8'h0B);

  function automatic kind_t decode_kind(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LOAD:                              return K_LOAD;
      OP_STORE:                             return K_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MPY: return K_ALU;
      OP_JMP:                               return K_JMP;
      OP_JMPGEZ:                            return K_JGEZ;
      OP_HALT:                              return K_HALT;
      default:                              return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] decode_alu(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:  return 3'b001;
      OP_AND:  return 3'b010;
      OP_OR:   return 3'b011;
      OP_MPY:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt_q;
  kind_t               kind;
  logic                unused_inputs;

  // Only the N flag steers the sequencer; the other flag bits pass through the datapath.
`ifdef CU_SINGLE_STEP_EN
  assign unused_inputs = ^{bus.flags[4:2], bus.flags[0]};
`else
  assign unused_inputs = ^{bus.flags[4:2], bus.flags[0], i_step};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Opcode is captured at the end of D1 and the N flag at the end of D2, so
  // the execute states see stable decode values even if the datapath moves on.
  // NOTE: these holding registers are reset too, so a post-reset decode never
  // sees X even though their value is don't-care until first written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      opcode_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (state_q == D1) opcode_q <= bus.opcode;
      if (state_q == D2) neg_q    <= bus.flags[1];
      if (state_q == F3) cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  assign kind        = decode_kind(opcode_q);
  assign o_instr_cnt = cnt_q;
  assign o_state     = state_q;

  // NOTE: every output and state_d gets a default first so no path through the
  // case statement leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    bus.ctrl    = '0;
    bus.alu_op  = '0;
    bus.mar_inc = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    o_halt      = 1'b0;
    o_illegal   = 1'b0;

    case (state_q)
      IDLE: if (i_start) state_d = FETCH_ENTRY;
`ifdef CU_SINGLE_STEP_EN
      STEP_WAIT: if (i_step) state_d = F1;
`endif
      F1: begin
        bus.ctrl[2] = 1'b1;
        state_d     = F2;
      end
      F2: begin
        bus.ctrl[5] = 1'b1;
        bus.mem_rd  = 1'b1;
        if (bus.mem_ready) state_d = F3;
      end
      F3: begin
        bus.ctrl[4] = 1'b1;
        state_d     = D1;
      end
      D1: begin
        bus.ctrl[14] = 1'b1;
        bus.ctrl[15] = 1'b1;
        state_d      = D2;
      end
      D2: begin
        bus.ctrl[8] = 1'b1;
        state_d     = (kind == K_HALT) ? HALTED : E1;
      end
      E1: begin
        case (kind)
          K_LOAD, K_ALU: begin
            bus.ctrl[5] = 1'b1;
            bus.mem_rd  = 1'b1;
            if (bus.mem_ready) state_d = E2;
          end
          K_STORE: begin
            bus.ctrl[12] = 1'b1;
            state_d      = E2;
          end
          K_JMP: begin
            bus.ctrl[3] = 1'b1;
            state_d     = FETCH_ENTRY;
          end
          K_JGEZ: begin
            bus.ctrl[3] = ~neg_q;
            state_d     = FETCH_ENTRY;
          end
          default: begin
            o_illegal = 1'b1;
            state_d   = FETCH_ENTRY;
          end
        endcase
      end
      E2: begin
        state_d = FETCH_ENTRY;
        case (kind)
          K_LOAD:  bus.ctrl[11] = 1'b1;
          K_STORE: begin
            bus.ctrl[13] = 1'b1;
            bus.mem_wr   = 1'b1;
          end
          K_ALU: begin
            bus.ctrl[6] = 1'b1;
            bus.ctrl[7] = 1'b1;
            bus.alu_op  = {1'b1, decode_alu(opcode_q)};
            state_d     = E3;
          end
          default: ;
        endcase
      end
      E3: begin
        bus.ctrl[9]  = 1'b1;
        bus.ctrl[10] = (opcode_q == OP_MPY);
        state_d      = FETCH_ENTRY;
      end
      HALTED: o_halt = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule
